ctrl_pipe: RTL
==============

Name: ctrl_pipe

Overview:
- Pipelined control unit for the 5-stage MIPS core. Decodes opcode/funct in ID into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers.
- Contains load-use/RAW hazard detection, EX-stage forwarding selects, and flush/freeze handling.
- Replaces the purely combinational decoder. Datapath muxes read their controls directly from the stage outputs.

Parameters:
- RA_W, 5, register-address width.
- LINK_REG, 31, destination register written by jal.
- FWD_EN, 1:
  - 1: forwarding enabled; stall only on load-use.
  - 0: fwd_a/fwd_b tied to 00; stall on any RAW against EX or MEM.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- opcode  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- id_rs, id_rt, id_rd  in  RA_W  source/destination fields in ID
- freeze  in  1  global stall (memory wait); all stage registers hold
- flush  in  1  branch/jump resolved taken in EX; squash the instruction in ID
- lu_stall  out  1  comb; hold PC and IF/ID, inject a bubble into ID/EX
- id_illegal  out  1  comb; id_valid and opcode not in decode table
- ex_valid, ex_signext, ex_alusrc, ex_regdst, ex_branch, ex_branchne, ex_jump, ex_jumpr, ex_link  out  1 each  EX controls
- ex_aluop  out  2  ALU class
- ex_wraddr  out  RA_W  resolved destination register
- fwd_a, fwd_b  out  2  ALU operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- mem_valid, mem_read, mem_write, mem_regwrite, mem_memtoreg  out  1 each
- mem_wraddr  out  RA_W
- wb_valid, wb_regwrite, wb_memtoreg  out  1 each
- wb_wraddr  out  RA_W

Behaviour:
- Reset:
  - rst_n low clears every stage register immediately (async).
  - All registered outputs read 0. Reset mid-operation discards all in-flight instructions.
- Decode (comb, ID). Unlisted control bits are 0.
  - lw 0x23: signext, aluop 00, alusrc, memread, memtoreg, rd1, regwrite, dst=rt.
  - sw 0x2b: signext, aluop 00, alusrc, memwrite, rd1, rd2.
  - beq 0x04 / bne 0x05: signext, aluop 01, rd1, rd2, branch, branchne=opcode[0].
  - j 0x02: aluop 11, jump.
  - jal 0x03: aluop 11, jump, link, regwrite, dst=LINK_REG.
  - opcode 0x00, funct 0x08 (jr): aluop 11, rd1, jump, jumpr.
  - opcode 0x00, other funct: aluop 10, rd1, rd2, regwrite, regdst, dst=rd.
  - 001xxx: signext=~opcode[2], aluop 10, alusrc, rd1, regwrite, dst=rt.
  - Other opcodes: all-zero bundle, id_illegal=1.
- Stage advance priority, per clock edge:
  1. freeze: all three stage registers hold. flush and lu_stall are ignored; the EX unit keeps flush high until freeze drops.
  2. flush: ID/EX loads zero bundle (ex_valid=0).
  3. lu_stall: ID/EX loads zero bundle.
  4. Otherwise: ID/EX loads the decode bundle, gated by id_valid.
  - EX/MEM and MEM/WB always advance when not frozen.
- Latency: instruction decoded at edge n shows on ex_* after n, mem_* after n+1, wb_* after n+2.
- ex_wraddr: link ? LINK_REG : regdst ? id_rd : id_rt, captured at ID/EX load. id_rs/id_rt are also registered for forwarding.
- Hazards. Match = source used (rd1/rd2), producer regwrite=1, wraddr != 0, addresses equal.
  - FWD_EN=1: lu_stall = id_valid & ex_memread & match against ex_wraddr.
  - FWD_EN=0: lu_stall = id_valid & (match vs EX | match vs MEM). The register file is write-before-read, so WB never stalls.
  - lu_stall is forced 0 while flush=1; the squashed instruction does not stall.
- Forwarding (FWD_EN=1), evaluated against the registered EX sources:
  - fwd_a = 10 if mem_regwrite & mem_wraddr!=0 & mem_wraddr==ex_rs.
  - else 01 if wb_regwrite & wb_wraddr!=0 & wb_wraddr==ex_rs.
  - else 00.
  - fwd_b is the same with ex_rt. MEM beats WB when both match.
- Bubbles carry regwrite=0, memread=0, memwrite=0, so they never trigger hazards or forwarding.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 3 instructions in flight -> all outputs 0 asynchronously; after release, first lw reaches wb_regwrite=1, wb_memtoreg=1 three edges after load.
- Load-use: lw $9,0($4); add $10,$9,$5 -> lu_stall=1 for exactly one cycle; ex_valid=0 for one cycle; add reaches EX with fwd_a=01.
- Back-to-back ALU: addu $3,$1,$2; sub $4,$3,$3 -> no stall; fwd_a=10, fwd_b=10. With $0 as destination -> fwd 00.
- Flush: beq in EX, flush=1 with add in ID -> next cycle ex_valid=0, ex_regwrite path 0, mem_regwrite=0 one cycle later.
- Freeze: freeze=1 for 3 cycles with lw in MEM -> every ex_/mem_/wb_ output constant; resumes advancing the cycle after freeze drops. flush pulsed during freeze -> no effect.
- FWD_EN=0: addu $3; or $5,$3,$0 -> lu_stall=1 for 2 cycles, fwd_a/fwd_b stay 00. Opcode 0x3f -> id_illegal=1, zero bundle.

Source files
------------

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - pipelined MIPS control: ID decode, ID/EX-EX/MEM-MEM/WB control registers, hazards, forwarding
module ctrl_pipe #(
    parameter int RA_W     = 5,
    parameter int LINK_REG = 31,
    parameter bit FWD_EN   = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic [RA_W-1:0] id_rd,
    input  logic            freeze,
    input  logic            flush,
    output logic            lu_stall,
    output logic            id_illegal,
    output logic            ex_valid,
    output logic            ex_signext,
    output logic            ex_alusrc,
    output logic            ex_regdst,
    output logic            ex_branch,
    output logic            ex_branchne,
    output logic            ex_jump,
    output logic            ex_jumpr,
    output logic            ex_link,
    output logic [1:0]      ex_aluop,
    output logic [RA_W-1:0] ex_wraddr,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            mem_valid,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem_regwrite,
    output logic            mem_memtoreg,
    output logic [RA_W-1:0] mem_wraddr,
    output logic            wb_valid,
    output logic            wb_regwrite,
    output logic            wb_memtoreg,
    output logic [RA_W-1:0] wb_wraddr
);

    localparam logic [RA_W-1:0] LP_LINK = RA_W'(LINK_REG);

    typedef struct packed {
        logic       signext;
        logic       alusrc;
        logic       regdst;
        logic       branch;
        logic       branchne;
        logic       jump;
        logic       jumpr;
        logic       link;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic [1:0] aluop;
    } ctrl_t;

    ctrl_t           w_ctl;
    logic            w_rd1;
    logic            w_rd2;
    logic            w_illegal;
    logic [RA_W-1:0] w_id_wraddr;
    logic            w_hit_ex;
    logic            w_hit_mem;
    logic            w_stall_raw;
    logic [1:0]      w_fwd_a;
    logic [1:0]      w_fwd_b;

    ctrl_t           r_ex_ctl;
    logic            r_ex_valid;
    logic [RA_W-1:0] r_ex_wraddr;
    logic [RA_W-1:0] r_ex_rs;
    logic [RA_W-1:0] r_ex_rt;
    logic            r_mem_valid;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_mem_regwrite;
    logic            r_mem_memtoreg;
    logic [RA_W-1:0] r_mem_wraddr;
    logic            r_wb_valid;
    logic            r_wb_regwrite;
    logic            r_wb_memtoreg;
    logic [RA_W-1:0] r_wb_wraddr;

    always_comb begin
        w_ctl     = '0;
        w_rd1     = 1'b0;
        w_rd2     = 1'b0;
        w_illegal = 1'b0;
        casez (opcode)
            6'h23: begin
                w_ctl.signext  = 1'b1;
                w_ctl.alusrc   = 1'b1;
                w_ctl.memread  = 1'b1;
                w_ctl.memtoreg = 1'b1;
                w_ctl.regwrite = 1'b1;
                w_rd1          = 1'b1;
            end
            6'h2b: begin
                w_ctl.signext  = 1'b1;
                w_ctl.alusrc   = 1'b1;
                w_ctl.memwrite = 1'b1;
                w_rd1          = 1'b1;
                w_rd2          = 1'b1;
            end
            6'h04, 6'h05: begin
                w_ctl.signext  = 1'b1;
                w_ctl.aluop    = 2'b01;
                w_ctl.branch   = 1'b1;
                w_ctl.branchne = opcode[0];
                w_rd1          = 1'b1;
                w_rd2          = 1'b1;
            end
            6'h02: begin
                w_ctl.aluop = 2'b11;
                w_ctl.jump  = 1'b1;
            end
            6'h03: begin
                w_ctl.aluop    = 2'b11;
                w_ctl.jump     = 1'b1;
                w_ctl.link     = 1'b1;
                w_ctl.regwrite = 1'b1;
            end
            6'h00: begin
                if (funct == 6'h08) begin
                    w_ctl.aluop = 2'b11;
                    w_ctl.jump  = 1'b1;
                    w_ctl.jumpr = 1'b1;
                    w_rd1       = 1'b1;
                end else begin
                    w_ctl.aluop    = 2'b10;
                    w_ctl.regwrite = 1'b1;
                    w_ctl.regdst   = 1'b1;
                    w_rd1          = 1'b1;
                    w_rd2          = 1'b1;
                end
            end
            // Immediate ALU ops: andi/ori/xori/lui (opcode[2]=1) zero-extend.
            6'b001???: begin
                w_ctl.signext  = ~opcode[2];
                w_ctl.aluop    = 2'b10;
                w_ctl.alusrc   = 1'b1;
                w_ctl.regwrite = 1'b1;
                w_rd1          = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign id_illegal  = id_valid & w_illegal;
    assign w_id_wraddr = w_ctl.link ? LP_LINK : (w_ctl.regdst ? id_rd : id_rt);

    assign w_hit_ex  = r_ex_ctl.regwrite && (r_ex_wraddr != '0) &&
                       ((w_rd1 && (id_rs == r_ex_wraddr)) || (w_rd2 && (id_rt == r_ex_wraddr)));
    assign w_hit_mem = r_mem_regwrite && (r_mem_wraddr != '0) &&
                       ((w_rd1 && (id_rs == r_mem_wraddr)) || (w_rd2 && (id_rt == r_mem_wraddr)));

    // Without forwarding, any producer still in EX or MEM must reach WB before ID reads.
    assign w_stall_raw = FWD_EN ? (r_ex_ctl.memread & w_hit_ex) : (w_hit_ex | w_hit_mem);
    assign lu_stall    = id_valid & ~flush & w_stall_raw;

    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (r_mem_regwrite && (r_mem_wraddr != '0) && (r_mem_wraddr == r_ex_rs))
            w_fwd_a = 2'b10;
        else if (r_wb_regwrite && (r_wb_wraddr != '0) && (r_wb_wraddr == r_ex_rs))
            w_fwd_a = 2'b01;
        if (r_mem_regwrite && (r_mem_wraddr != '0) && (r_mem_wraddr == r_ex_rt))
            w_fwd_b = 2'b10;
        else if (r_wb_regwrite && (r_wb_wraddr != '0) && (r_wb_wraddr == r_ex_rt))
            w_fwd_b = 2'b01;
    end

    assign fwd_a = FWD_EN ? w_fwd_a : 2'b00;
    assign fwd_b = FWD_EN ? w_fwd_b : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_ctl       <= '0;
            r_ex_valid     <= 1'b0;
            r_ex_wraddr    <= '0;
            r_ex_rs        <= '0;
            r_ex_rt        <= '0;
            r_mem_valid    <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_mem_wraddr   <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_regwrite  <= 1'b0;
            r_wb_memtoreg  <= 1'b0;
            r_wb_wraddr    <= '0;
        end else if (!freeze) begin
            r_mem_valid    <= r_ex_valid;
            r_mem_read     <= r_ex_ctl.memread;
            r_mem_write    <= r_ex_ctl.memwrite;
            r_mem_regwrite <= r_ex_ctl.regwrite;
            r_mem_memtoreg <= r_ex_ctl.memtoreg;
            r_mem_wraddr   <= r_ex_wraddr;
            r_wb_valid     <= r_mem_valid;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_memtoreg  <= r_mem_memtoreg;
            r_wb_wraddr    <= r_mem_wraddr;
            if (flush || lu_stall || !id_valid) begin
                r_ex_ctl    <= '0;
                r_ex_valid  <= 1'b0;
                r_ex_wraddr <= '0;
                r_ex_rs     <= '0;
                r_ex_rt     <= '0;
            end else begin
                r_ex_ctl    <= w_ctl;
                r_ex_valid  <= 1'b1;
                r_ex_wraddr <= w_id_wraddr;
                r_ex_rs     <= id_rs;
                r_ex_rt     <= id_rt;
            end
        end
    end

    assign ex_valid     = r_ex_valid;
    assign ex_signext   = r_ex_ctl.signext;
    assign ex_alusrc    = r_ex_ctl.alusrc;
    assign ex_regdst    = r_ex_ctl.regdst;
    assign ex_branch    = r_ex_ctl.branch;
    assign ex_branchne  = r_ex_ctl.branchne;
    assign ex_jump      = r_ex_ctl.jump;
    assign ex_jumpr     = r_ex_ctl.jumpr;
    assign ex_link      = r_ex_ctl.link;
    assign ex_aluop     = r_ex_ctl.aluop;
    assign ex_wraddr    = r_ex_wraddr;
    assign mem_valid    = r_mem_valid;
    assign mem_read     = r_mem_read;
    assign mem_write    = r_mem_write;
    assign mem_regwrite = r_mem_regwrite;
    assign mem_memtoreg = r_mem_memtoreg;
    assign mem_wraddr   = r_mem_wraddr;
    assign wb_valid     = r_wb_valid;
    assign wb_regwrite  = r_wb_regwrite;
    assign wb_memtoreg  = r_wb_memtoreg;
    assign wb_wraddr    = r_wb_wraddr;

endmodule
